// File: rtl/jtdd_vtimer_if.sv
`default_nettype none
// ============================================================================
//  Module   : jtdd_vtimer_if
//  Purpose  : CPU-side raster interrupt bus of the video timer
//             (compare line write, acknowledge, interrupt level).
//  Revision : 1.0 - initial release
// ============================================================================
interface jtdd_vtimer_if #(
    parameter int VW = 9
) ();
    logic          irq_we;
    logic [VW-1:0] irq_din;
    logic          irq_ack;
    logic          irq;

    modport master (output irq_we, irq_din, irq_ack, input irq);
    modport slave  (input irq_we, irq_din, irq_ack, output irq);
endinterface
`default_nettype wire

// File: rtl/jtdd_vtimer.sv
`default_nettype none
// ============================================================================
//  Module   : jtdd_vtimer
//  Purpose  : Parametrised H/V video timing generator with delayed blanks,
//             flip-corrected position and raster IRQ.
//             Optional freeze input enabled by macro VTIMER_HOLD_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module jtdd_vtimer #(
    parameter int HW       = 9,
    parameter int VW       = 9,
    parameter int H_START  = 0,
    parameter int H_END    = 383,
    parameter int V_START  = 0,
    parameter int V_END    = 271,
    parameter int HB_START = 256,
    parameter int HB_END   = 0,
    parameter int HS_START = 288,
    parameter int HS_END   = 320,
    parameter int VB_START = 240,
    parameter int VB_END   = 16,
    parameter int VS_START = 248,
    parameter int VS_END   = 251,
    parameter int IRQ_H    = 256,
    parameter int IMS_BIT  = 3,
    parameter int DLY      = 2
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          i_pxl_cen,
    input  wire logic          i_flip,
`ifdef VTIMER_HOLD_EN
    input  wire logic          i_hold,
`endif
    jtdd_vtimer_if.slave       bus,
    output logic [HW-1:0]      o_hcnt,
    output logic [VW-1:0]      o_vcnt,
    output logic [HW-1:0]      o_hpos,
    output logic [VW-1:0]      o_vpos,
    output logic               o_hbl,
    output logic               o_vbl,
    output logic               o_hs,
    output logic               o_vs,
    output logic               o_lhbl_dly,
    output logic               o_lvbl_dly,
    output logic               o_ims
);
    localparam logic [HW-1:0] c_h_start  = HW'(H_START);
    localparam logic [HW-1:0] c_h_end    = HW'(H_END);
    localparam logic [VW-1:0] c_v_start  = VW'(V_START);
    localparam logic [VW-1:0] c_v_end    = VW'(V_END);
    localparam logic [HW-1:0] c_hb_start = HW'(HB_START);
    localparam logic [HW-1:0] c_hb_end   = HW'(HB_END);
    localparam logic [HW-1:0] c_hs_start = HW'(HS_START);
    localparam logic [HW-1:0] c_hs_end   = HW'(HS_END);
    localparam logic [VW-1:0] c_vb_start = VW'(VB_START);
    localparam logic [VW-1:0] c_vb_end   = VW'(VB_END);
    localparam logic [VW-1:0] c_vs_start = VW'(VS_START);
    localparam logic [VW-1:0] c_vs_end   = VW'(VS_END);
    localparam logic [HW-1:0] c_irq_h    = HW'(IRQ_H);

    if (H_START == H_END || V_START == V_END || HB_START == HB_END ||
        HS_START == HS_END || VB_START == VB_END || VS_START == VS_END ||
        DLY < 0 || DLY > 7) begin : g_bad_param
        $error("jtdd_vtimer: illegal parameter set");
    end

    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;
    logic          r_hbl, r_vbl, r_hs, r_vs;
    logic [VW-1:0] r_irq_line;
    logic          r_irq;

    logic          w_adv;
    logic          w_hwrap;
    logic [HW-1:0] w_hnext;
    logic [VW-1:0] w_vnext;
    logic          w_irq_set;

`ifdef VTIMER_HOLD_EN
    assign w_adv = i_pxl_cen & ~i_hold;
`else
    assign w_adv = i_pxl_cen;
`endif

    assign w_hwrap   = (r_hcnt == c_h_end);
    assign w_hnext   = w_hwrap ? c_h_start : r_hcnt + 1'b1;
    assign w_vnext   = !w_hwrap ? r_vcnt :
                       (r_vcnt == c_v_end) ? c_v_start : r_vcnt + 1'b1;
    // Compare against the count being entered so irq lines up with hcnt==IRQ_H
    assign w_irq_set = w_adv && (w_hnext == c_irq_h) && (w_vnext == r_irq_line);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt <= c_h_start;
            r_vcnt <= c_v_start;
            r_hbl  <= 1'b1;
            r_vbl  <= 1'b1;
            r_hs   <= 1'b0;
            r_vs   <= 1'b0;
        end else if (w_adv) begin
            r_hcnt <= w_hnext;
            r_vcnt <= w_vnext;
            if (w_hnext == c_hb_start)    r_hbl <= 1'b1;
            else if (w_hnext == c_hb_end) r_hbl <= 1'b0;
            if (w_hnext == c_hs_start)    r_hs  <= 1'b1;
            else if (w_hnext == c_hs_end) r_hs  <= 1'b0;
            if (w_hwrap) begin
                if (w_vnext == c_vb_start)    r_vbl <= 1'b1;
                else if (w_vnext == c_vb_end) r_vbl <= 1'b0;
                if (w_vnext == c_vs_start)    r_vs  <= 1'b1;
                else if (w_vnext == c_vs_end) r_vs  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_line <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (bus.irq_we) r_irq_line <= bus.irq_din;
            if (w_irq_set)        r_irq <= 1'b1;
            else if (bus.irq_ack) r_irq <= 1'b0;
        end
    end

    if (DLY == 0) begin : g_nodly
        assign o_lhbl_dly = ~r_hbl;
        assign o_lvbl_dly = ~r_vbl;
    end else begin : g_dly
        logic [DLY-1:0] r_hpipe, r_vpipe;
        logic [DLY:0]   w_hsh, w_vsh;
        assign w_hsh = {r_hpipe, ~r_hbl};
        assign w_vsh = {r_vpipe, ~r_vbl};
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_hpipe <= '0;
                r_vpipe <= '0;
            end else if (w_adv) begin
                r_hpipe <= w_hsh[DLY-1:0];
                r_vpipe <= w_vsh[DLY-1:0];
            end
        end
        assign o_lhbl_dly = r_hpipe[DLY-1];
        assign o_lvbl_dly = r_vpipe[DLY-1];
    end

    assign o_hcnt  = r_hcnt;
    assign o_vcnt  = r_vcnt;
    assign o_hpos  = i_flip ? ~r_hcnt : r_hcnt;
    assign o_vpos  = i_flip ? ~r_vcnt : r_vcnt;
    assign o_hbl   = r_hbl;
    assign o_vbl   = r_vbl;
    assign o_hs    = r_hs;
    assign o_vs    = r_vs;
    assign o_ims   = r_vcnt[IMS_BIT];
    assign bus.irq = r_irq;
endmodule
`default_nettype wire
